// File: rtl/motor_seq_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : motor_seq_arbiter_if
//  Description : Avalon-MM write-master bundle between the motor command
//                sequencer and the PWM register slave.
//                  s_cs        - chip select
//                  s_address   - register address (ADDR_W bits)
//                  s_write     - write strobe
//                  s_read      - read strobe (never used by the master)
//                  s_writedata - write data (DATA_W bits)
//                  waitrequest - slave stall, driven by the slave
//                Modports: master (sequencer side), slave (PWM side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface motor_seq_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              s_cs;
    logic [ADDR_W-1:0] s_address;
    logic              s_write;
    logic              s_read;
    logic [DATA_W-1:0] s_writedata;
    logic              waitrequest;

    modport master (
        output s_cs,
        output s_address,
        output s_write,
        output s_read,
        output s_writedata,
        input  waitrequest
    );

    modport slave (
        input  s_cs,
        input  s_address,
        input  s_write,
        input  s_read,
        input  s_writedata,
        output waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/motor_seq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : motor_seq_arbiter
//  Description : Two-requester round-robin arbiter that turns a motor command
//                (high duration, period, control bits) into three Avalon-MM
//                register writes to a PWM slave: HIGH (addr 1), TOTAL (addr 0),
//                CTRL (addr 2), then pulses ack for the served requester.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                req[1:0]        - per-requester command request
//                ack[1:0]        - per-requester one-cycle completion pulse
//                high_dur0/1     - requested PWM high duration
//                total_dur0/1    - requested PWM period
//                ctrl0/1         - {fast_decay, forward, go}
//                bus             - Avalon-MM master modport
//                busy            - high while not IDLE
//                grant_id        - requester currently served
//  Options     : MOTOR_DUTY_CLAMP_EN - when defined, a high duration larger
//                than the period is clamped to the period before writing.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_seq_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [1:0]        req,
    output logic      [1:0]        ack,
    input  wire logic [DATA_W-1:0] high_dur0,
    input  wire logic [DATA_W-1:0] high_dur1,
    input  wire logic [DATA_W-1:0] total_dur0,
    input  wire logic [DATA_W-1:0] total_dur1,
    input  wire logic [2:0]        ctrl0,
    input  wire logic [2:0]        ctrl1,
    motor_seq_arbiter_if.master    bus,
    output logic                   busy,
    output logic                   grant_id
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_HIGH  = 3'd1,
        W_TOTAL = 3'd2,
        W_CTRL  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_TOTAL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_HIGH  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = ADDR_W'(2);

    state_t            state_q;
    logic              last_q;      // requester granted most recently
    logic              grant_q;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] total_q;
    logic [2:0]        ctrl_q;
    logic              cs_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              win_d;
    logic [DATA_W-1:0] high_sel_d;
    logic [DATA_W-1:0] total_sel_d;
    logic [2:0]        ctrl_sel_d;

    // Winner selection and operand mux; only consumed in IDLE.
    always_comb begin
        win_d = ~last_q;            // both requesting: the one not served last
        if (req == 2'b01) begin
            win_d = 1'b0;
        end else if (req == 2'b10) begin
            win_d = 1'b1;
        end
        high_sel_d  = win_d ? high_dur1  : high_dur0;
        total_sel_d = win_d ? total_dur1 : total_dur0;
        ctrl_sel_d  = win_d ? ctrl1      : ctrl0;
`ifdef MOTOR_DUTY_CLAMP_EN
        if (high_sel_d > total_sel_d) begin
            high_sel_d = total_sel_d;
        end
`endif
    end

    // Bus outputs are registered and loaded on the transition into each
    // state, so they line up with the state register. A stalled write
    // simply does not enter any branch, leaving state and outputs held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;        // favours requester 0 after reset
            grant_q <= 1'b0;
            ack_q   <= 2'b00;
            total_q <= '0;
            ctrl_q  <= 3'b000;
            cs_q    <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q <= win_d;
                        last_q  <= win_d;
                        total_q <= total_sel_d;
                        ctrl_q  <= ctrl_sel_d;
                        cs_q    <= 1'b1;
                        write_q <= 1'b1;
                        addr_q  <= ADDR_HIGH;
                        wdata_q <= high_sel_d;
                        state_q <= W_HIGH;
                    end
                end
                W_HIGH: begin
                    if (!bus.waitrequest) begin
                        addr_q  <= ADDR_TOTAL;
                        wdata_q <= total_q;
                        state_q <= W_TOTAL;
                    end
                end
                W_TOTAL: begin
                    if (!bus.waitrequest) begin
                        addr_q  <= ADDR_CTRL;
                        wdata_q <= {{(DATA_W-3){1'b0}}, ctrl_q};
                        state_q <= W_CTRL;
                    end
                end
                W_CTRL: begin
                    if (!bus.waitrequest) begin
                        cs_q           <= 1'b0;
                        write_q        <= 1'b0;
                        addr_q         <= '0;
                        wdata_q        <= '0;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack             = ack_q;
    assign busy            = (state_q != IDLE);
    assign grant_id        = grant_q;
    assign bus.s_cs        = cs_q;
    assign bus.s_write     = write_q;
    assign bus.s_read      = 1'b0;
    assign bus.s_address   = addr_q;
    assign bus.s_writedata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_seq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_seq_arbiter
//  Description : Self-checking bench for motor_seq_arbiter. Expected bus
//                writes and acks are queued when a command is issued and
//                compared by a negedge monitor as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_seq_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        ack;
    logic [DATA_W-1:0] high_dur0, high_dur1, total_dur0, total_dur1;
    logic [2:0]        ctrl0, ctrl1;
    logic              busy;
    logic              grant_id;
    logic              wr;

    motor_seq_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    assign bus.waitrequest = wr;

    motor_seq_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ack        (ack),
        .high_dur0  (high_dur0),
        .high_dur1  (high_dur1),
        .total_dur0 (total_dur0),
        .total_dur1 (total_dur1),
        .ctrl0      (ctrl0),
        .ctrl1      (ctrl1),
        .bus        (bus.master),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int hold_cnt = 0;
    bit hold_en  = 1'b0;

    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [2:0]               exp_ack[$];   // {grant_id, ack}
    int                       wr_cyc[$];

    logic [ADDR_W+DATA_W-1:0] mon_got, mon_exp;
    logic [2:0]               mon_ag, mon_ae;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: an accepted write is a cycle with cs&write and no stall.
    always @(negedge clk) begin
        if (!reset && bus.s_cs && bus.s_write && !wr) begin
            mon_got = {bus.s_address, bus.s_writedata};
            wr_cyc.push_back(cyc);
            chk_cnt++;
            if (exp_wr.size() == 0) begin
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         bus.s_address, bus.s_writedata);
            end else begin
                mon_exp = exp_wr.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                             mon_got[ADDR_W+DATA_W-1:DATA_W], mon_got[DATA_W-1:0],
                             mon_exp[ADDR_W+DATA_W-1:DATA_W], mon_exp[DATA_W-1:0]);
                else
                    pass_cnt++;
            end
        end
        if (!reset && ack !== 2'b00) begin
            mon_ag = {grant_id, ack};
            chk_cnt++;
            if (exp_ack.size() == 0) begin
                $display("FAIL unexpected_ack: got ack %b grant %0d, expected none", ack, grant_id);
            end else begin
                mon_ae = exp_ack.pop_front();
                if (mon_ag !== mon_ae)
                    $display("FAIL ack: got grant/ack %b, expected %b", mon_ag, mon_ae);
                else
                    pass_cnt++;
            end
        end
        if (hold_en && bus.s_cs && bus.s_write && bus.s_address == 4'd0 &&
            bus.s_writedata == 32'd7000)
            hold_cnt++;
    end

    // Expected results for one complete transaction.
    task automatic push_txn(input int n, input logic [31:0] hi, input logic [31:0] tot,
                            input logic [2:0] c);
        logic [31:0] hw;
        logic        g;
        hw = hi;
`ifdef MOTOR_DUTY_CLAMP_EN
        if (hi > tot) hw = tot;
`endif
        g = (n == 1);
        exp_wr.push_back({4'd1, hw});
        exp_wr.push_back({4'd0, tot});
        exp_wr.push_back({4'd2, 29'd0, c});
        exp_ack.push_back({g, g ? 2'b10 : 2'b01});
    endtask

    task automatic drive_cmd(input int n, input logic [31:0] hi, input logic [31:0] tot,
                             input logic [2:0] c);
        if (n == 0) begin
            high_dur0 = hi; total_dur0 = tot; ctrl0 = c; req[0] = 1'b1;
        end else begin
            high_dur1 = hi; total_dur1 = tot; ctrl1 = c; req[1] = 1'b1;
        end
    endtask

    // Counts negedges until ack[n]; drops req[n] in the following cycle.
    task automatic wait_ack(input int n, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (ack[n]) break;
            if (cycles >= 60) begin
                chk_cnt++;
                $display("FAIL ack_timeout: got no ack[%0d] after %0d cycles, expected ack", n, cycles);
                break;
            end
        end
        @(posedge clk); #1;
        req[n] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({ack, bus.s_cs, bus.s_write, bus.s_read, bus.s_address, bus.s_writedata,
             busy, grant_id} !== '0)
            $display("FAIL reset_outputs: got ack %b cs %b wr %b rd %b addr %0d data %0d busy %b gid %b, expected all 0",
                     ack, bus.s_cs, bus.s_write, bus.s_read, bus.s_address, bus.s_writedata, busy, grant_id);
        else
            pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_both;
        int  n;
        bit  d0, d1;
        logic [1:0] a;
        @(posedge clk); #1;
        push_txn(0, 32'd1000, 32'd2000, 3'b001);
        push_txn(1, 32'd1500, 32'd3000, 3'b110);
        drive_cmd(0, 32'd1000, 32'd2000, 3'b001);
        drive_cmd(1, 32'd1500, 32'd3000, 3'b110);
        n = 0; d0 = 1'b0; d1 = 1'b0;
        while (!(d0 && d1) && n < 100) begin
            @(negedge clk);
            n++;
            a = ack;
            @(posedge clk); #1;
            if (a[0]) begin req[0] = 1'b0; d0 = 1'b1; end
            if (a[1]) begin req[1] = 1'b0; d1 = 1'b1; end
        end
        chk_cnt++;
        if (!(d0 && d1))
            $display("FAIL both_timeout: got acks %b%b, expected 11", d1, d0);
        else
            pass_cnt++;
        req = 2'b00;
    endtask

    task automatic test_basic;
        int c;
        @(posedge clk); #1;
        wr_cyc.delete();
        push_txn(0, 32'd3500, 32'd7000, 3'b011);
        drive_cmd(0, 32'd3500, 32'd7000, 3'b011);
        wait_ack(0, c);
        chk_cnt++;
        if (c !== 5) $display("FAIL ack_latency: got %0d cycles, expected 5", c);
        else pass_cnt++;
        chk_cnt++;
        if (wr_cyc.size() != 3 || wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1)
            $display("FAIL consecutive_writes: got %0d writes not back to back, expected 3 consecutive",
                     wr_cyc.size());
        else
            pass_cnt++;
    endtask

    task automatic test_waitreq;
        int c;
        @(posedge clk); #1;
        hold_cnt = 0;
        hold_en  = 1'b1;
        push_txn(1, 32'd3500, 32'd7000, 3'b001);
        drive_cmd(1, 32'd3500, 32'd7000, 3'b001);
        @(posedge clk);
        @(posedge clk); #1;          // now in W_TOTAL
        wr = 1'b1;
        repeat (5) @(posedge clk);
        #1 wr = 1'b0;
        wait_ack(1, c);
        hold_en = 1'b0;
        chk_cnt++;
        if (hold_cnt !== 6) $display("FAIL total_hold: got %0d cycles, expected 6", hold_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int c;
        bit seen;
        @(posedge clk); #1;
        exp_wr.push_back({4'd1, 32'd100});
        exp_wr.push_back({4'd0, 32'd200});
        drive_cmd(0, 32'd100, 32'd200, 3'b101);
        repeat (3) @(posedge clk);   // W_CTRL after the third edge
        #1;
        reset  = 1'b1;
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({ack, bus.s_cs, bus.s_write, bus.s_address, bus.s_writedata, busy, grant_id} !== '0)
            $display("FAIL mid_reset_outputs: got ack %b cs %b wr %b addr %0d data %0d busy %b gid %b, expected all 0",
                     ack, bus.s_cs, bus.s_write, bus.s_address, bus.s_writedata, busy, grant_id);
        else
            pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 2'b00) seen = 1'b1;
        end
        chk_cnt++;
        if (seen) $display("FAIL abandoned_ack: got ack after reset, expected none");
        else pass_cnt++;
        @(posedge clk); #1;
        push_txn(1, 32'd400, 32'd800, 3'b011);
        drive_cmd(1, 32'd400, 32'd800, 3'b011);
        wait_ack(1, c);
        chk_cnt++;
        if (c !== 5) $display("FAIL post_reset_latency: got %0d cycles, expected 5", c);
        else pass_cnt++;
    endtask

    task automatic test_clamp;
        int c;
        @(posedge clk); #1;
        push_txn(0, 32'd9000, 32'd7000, 3'b111);
        drive_cmd(0, 32'd9000, 32'd7000, 3'b111);
        wait_ack(0, c);
    endtask

    task automatic test_latch;
        int c;
        @(posedge clk); #1;
        push_txn(0, 32'd1234, 32'd5678, 3'b010);
        drive_cmd(0, 32'd1234, 32'd5678, 3'b010);
        @(posedge clk);
        @(posedge clk); #1;          // W_TOTAL: change inputs under the transaction
        high_dur0  = 32'd1;
        total_dur0 = 32'd2;
        ctrl0      = 3'b100;
        wait_ack(0, c);
    endtask

    initial begin
        req = 2'b00; wr = 1'b0; reset = 1'b1;
        high_dur0 = '0; high_dur1 = '0; total_dur0 = '0; total_dur1 = '0;
        ctrl0 = '0; ctrl1 = '0;
        test_reset;
        test_both;
        test_basic;
        test_waitreq;
        test_reset_mid;
        test_clamp;
        test_latch;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if (exp_wr.size() != 0) $display("FAIL pending_writes: got %0d left, expected 0", exp_wr.size());
        else pass_cnt++;
        chk_cnt++;
        if (exp_ack.size() != 0) $display("FAIL pending_acks: got %0d left, expected 0", exp_ack.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
